uart_rx_core: RTL

UART receive core that sits directly downstream of the baud rate generator. It consumes that generator's 16x-oversampled `baud_tick` enable and turns the asynchronous serial `rx` line into parallel bytes. It also flags parity and framing errors. Frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) is run-time programmable and latched per frame.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_core.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the synchronizer and the receive core.
package uart_pkg;

  localparam int UART_MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    DB5 = 2'b00,
    DB6 = 2'b01,
    DB7 = 2'b10,
    DB8 = 2'b11
  } data_bits_e;

  typedef struct packed {
    logic [2:0] last_idx;
    logic       par_en;
    logic       par_odd;
    logic       stop_2;
  } rx_fmt_t;

  // Index of the final data bit: 5 bits -> 4 ... 8 bits -> 7.
  function automatic logic [2:0] last_bit_idx(
    input data_bits_e sel
  );
    return {1'b1, sel};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an idle-high async input.
// Resets to all ones so no false edge is seen out of reset.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 5-8 data bits,
// optional parity, 1 or 2 stop bits, latched per frame.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       uart_ref_clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] data_bits_sel,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop_2,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF =
    CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(OVERSAMPLE - 1);

  logic w_rx_s;

  rx_state_e r_state, w_state;
  logic [CW-1:0] r_tick, w_tick;
  logic [2:0]    r_bit, w_bit;
  logic [UART_MAX_DATA_BITS-1:0] r_shift;
  logic [UART_MAX_DATA_BITS-1:0] w_shift;
  logic          r_par, w_par;
  logic          r_perr, w_perr;
  logic          r_ferr, w_ferr;
  logic          r_stop_cnt, w_stop_cnt;
  rx_fmt_t       r_fmt, w_fmt;
  logic [7:0]    r_rx_data, w_rx_data;
  logic          r_rx_valid, w_rx_valid;
  logic          r_par_out, w_par_out;
  logic          r_frm_out, w_frm_out;
  logic          w_ferr_now;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(uart_ref_clk),
    .rst(rst),
    .i_d(rx),
    .o_q(w_rx_s)
  );

  always_ff @(posedge uart_ref_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_fmt      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_par_out  <= 1'b0;
      r_frm_out  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tick     <= w_tick;
      r_bit      <= w_bit;
      r_shift    <= w_shift;
      r_par      <= w_par;
      r_perr     <= w_perr;
      r_ferr     <= w_ferr;
      r_stop_cnt <= w_stop_cnt;
      r_fmt      <= w_fmt;
      r_rx_data  <= w_rx_data;
      r_rx_valid <= w_rx_valid;
      r_par_out  <= w_par_out;
      r_frm_out  <= w_frm_out;
    end
  end

  assign w_ferr_now = r_ferr | ~w_rx_s;

  always_comb begin
    w_state    = r_state;
    w_tick     = r_tick;
    w_bit      = r_bit;
    w_shift    = r_shift;
    w_par      = r_par;
    w_perr     = r_perr;
    w_ferr     = r_ferr;
    w_stop_cnt = r_stop_cnt;
    w_fmt      = r_fmt;
    w_rx_data  = r_rx_data;
    w_rx_valid = 1'b0;
    w_par_out  = r_par_out;
    w_frm_out  = r_frm_out;

    if (baud_tick) begin
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state    = START;
            w_tick     = '0;
            w_bit      = '0;
            w_shift    = '0;
            w_par      = 1'b0;
            w_perr     = 1'b0;
            w_ferr     = 1'b0;
            w_stop_cnt = 1'b0;
            w_fmt.last_idx = last_bit_idx(
              data_bits_e'(data_bits_sel));
            w_fmt.par_en  = parity_en;
            w_fmt.par_odd = parity_odd;
            w_fmt.stop_2  = stop_2;
          end
        end
        START: begin
          if (r_tick == HALF) begin
            w_tick  = '0;
            w_state = w_rx_s ? IDLE : DATA;
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        DATA: begin
          if (r_tick == FULL) begin
            w_tick         = '0;
            w_shift[r_bit] = w_rx_s;
            w_par          = r_par ^ w_rx_s;
            if (r_bit == r_fmt.last_idx) begin
              w_state = r_fmt.par_en ? PARITY : STOP;
            end else begin
              w_bit = r_bit + 1'b1;
            end
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        PARITY: begin
          if (r_tick == FULL) begin
            w_tick  = '0;
            w_perr  = w_rx_s ^ r_par ^ r_fmt.par_odd;
            w_state = STOP;
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        STOP: begin
          if (r_tick == FULL) begin
            w_tick = '0;
            w_ferr = w_ferr_now;
            // Leave at mid stop bit so the next start edge is caught.
            if (r_fmt.stop_2 && !r_stop_cnt) begin
              w_stop_cnt = 1'b1;
            end else begin
              w_state    = IDLE;
              w_rx_valid = 1'b1;
              w_rx_data  = r_shift;
              w_par_out  = r_perr;
              w_frm_out  = w_ferr_now;
            end
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        default: begin
          w_state = IDLE;
          w_tick  = '0;
        end
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_par_out;
  assign frame_err  = r_frm_out;
  assign rx_busy    = (r_state != IDLE);

endmodule
